// File: rtl/ads131_timer_pkg.sv
// Shared definitions for the ADS131 sample-timer sequencer: timer register map,
// control word encodings, minimum accepted period and the sequencer state enum.
// No logic; imported by the sequencer top and its bus write port.
package ads131_timer_pkg;

   // Smallest period load value the sequencer will program into the timer.
   localparam logic [31:0] MIN_PERIOD = 32'd16;

   // Interval timer register addresses.
   localparam logic [2:0] TM_ADDR_STATUS   = 3'd0;
   localparam logic [2:0] TM_ADDR_CONTROL  = 3'd1;
   localparam logic [2:0] TM_ADDR_PERIOD_L = 3'd2;
   localparam logic [2:0] TM_ADDR_PERIOD_H = 3'd3;

   // Control register bit positions.
   localparam int CTRL_ITO   = 0;
   localparam int CTRL_CONT  = 1;
   localparam int CTRL_START = 2;
   localparam int CTRL_STOP  = 3;

   // Interrupt enabled, continuous, start: 0x0007.
   localparam logic [15:0] CTRL_RUN_WORD  = 16'((1 << CTRL_ITO) | (1 << CTRL_CONT) | (1 << CTRL_START));
   // Stop with interrupt disabled: 0x0008.
   localparam logic [15:0] CTRL_HALT_WORD = 16'(1 << CTRL_STOP);

   // Value written to the status register to clear the timeout flag.
   localparam logic [15:0] STATUS_CLEAR_WORD = 16'h0000;

   typedef enum logic [3:0] {
      ST_IDLE     = 4'd0,
      ST_WR_PL    = 4'd1,
      ST_WR_PH    = 4'd2,
      ST_WR_CTRL  = 4'd3,
      ST_RUN      = 4'd4,
      ST_CLR      = 4'd5,
      ST_CLR_HOLD = 4'd6,
      ST_WR_STOP  = 4'd7,
      ST_WR_FINAL = 4'd8
   } seq_state_t;

   // One timer bus write request.
   typedef struct packed {
      logic        vld;
      logic [2:0]  addr;
      logic [15:0] dat;
   } tm_wr_t;

endpackage

// File: rtl/ads131_tm_write_port.sv
// Timer bus write port: registers a one-cycle write request onto the timer bus.
// Latency: 1 clock from request to bus; the timer never stalls, so no backpressure.
// Ports: clk, reset_n (sync, active-low); wr_req/wr_address/wr_data request in;
//        tm_address/tm_chipselect/tm_write_n/tm_writedata registered bus out.
module ads131_tm_write_port
   import ads131_timer_pkg::*;
(
   input  logic        clk,
   input  logic        reset_n,
   input  logic        wr_req,
   input  logic [2:0]  wr_address,
   input  logic [15:0] wr_data,
   output logic [2:0]  tm_address,
   output logic        tm_chipselect,
   output logic        tm_write_n,
   output logic [15:0] tm_writedata
);

   tm_wr_t bus_q;

   // Idle bus is fully parked: address and data forced to zero between writes.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         bus_q <= '0;
      end else if (wr_req) begin
         bus_q <= '{vld: 1'b1, addr: wr_address, dat: wr_data};
      end else begin
         bus_q <= '0;
      end
   end

   assign tm_chipselect = bus_q.vld;
   assign tm_write_n    = ~bus_q.vld;
   assign tm_address    = bus_q.addr;
   assign tm_writedata  = bus_q.dat;

endmodule

// File: rtl/ads131_timer_sequencer.sv
// ADS131 sample-timer sequencer: programs an interval timer, services its
// timeouts as ADC sample ticks, and halts it after a burst or on stop.
// Latency: first timer write 1 clock after start; tick 1 clock after tm_irq.
// Backpressure: none; start while busy is dropped, timer accepts every write.
// Ports: clk, reset_n (sync, active-low); start/stop/period/burst_count control;
//        tm_irq in, tm_address/tm_chipselect/tm_write_n/tm_writedata timer bus;
//        tick/tick_count/busy/done/err status.
module ads131_timer_sequencer
   import ads131_timer_pkg::*;
(
   input  logic        clk,
   input  logic        reset_n,
   input  logic        start,
   input  logic        stop,
   input  logic [31:0] period,
   input  logic [15:0] burst_count,
   input  logic        tm_irq,
   output logic [2:0]  tm_address,
   output logic        tm_chipselect,
   output logic        tm_write_n,
   output logic [15:0] tm_writedata,
   output logic        tick,
   output logic [15:0] tick_count,
   output logic        busy,
   output logic        done,
   output logic        err
);

   seq_state_t  state;
   seq_state_t  next_state;

   logic [31:0] period_q;
   logic [15:0] burst_q;
   logic [15:0] tick_count_q;
   logic        tick_q;
   logic        done_q;
   logic        err_q;

   logic        start_req;
   logic        period_ok;
   logic        accept_start;
   logic        reject_start;
   logic        irq_service;
   logic        burst_done;

   tm_wr_t      wr_next;

   // start together with stop is treated as no request at all.
   assign start_req    = start & ~stop;
   assign period_ok    = (period >= MIN_PERIOD);
   assign accept_start = (state == ST_IDLE) & start_req & period_ok;
   assign reject_start = (state == ST_IDLE) & start_req & ~period_ok;

   // A timeout coinciding with stop is abandoned rather than serviced.
   assign irq_service  = (state == ST_RUN) & tm_irq & ~stop;
   assign burst_done   = (burst_q != 16'd0) & (tick_count_q == burst_q);

   // ------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state <= ST_IDLE;
      end else begin
         state <= next_state;
      end
   end

   // ------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------
   always_comb begin
      next_state = state;
      case (state)
         ST_IDLE: begin
            if (accept_start) begin
               next_state = ST_WR_PL;
            end
         end
         ST_WR_PL: begin
            next_state = stop ? ST_WR_STOP : ST_WR_PH;
         end
         ST_WR_PH: begin
            next_state = stop ? ST_WR_STOP : ST_WR_CTRL;
         end
         ST_WR_CTRL: begin
            next_state = stop ? ST_WR_STOP : ST_RUN;
         end
         ST_RUN: begin
            if (stop) begin
               next_state = ST_WR_STOP;
            end else if (tm_irq) begin
               next_state = ST_CLR;
            end
         end
         ST_CLR: begin
            next_state = stop ? ST_WR_STOP : ST_CLR_HOLD;
         end
         ST_CLR_HOLD: begin
            // The status clear lands at the end of CLR, so tm_irq may still
            // read stale here; it is deliberately not looked at.
            if (stop || burst_done) begin
               next_state = ST_WR_STOP;
            end else begin
               next_state = ST_RUN;
            end
         end
         ST_WR_STOP: begin
            next_state = ST_WR_FINAL;
         end
         ST_WR_FINAL: begin
            next_state = ST_IDLE;
         end
         default: begin
            next_state = ST_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Output logic
   // ------------------------------------------------------------------
   // The write request is decoded from next_state so that, after the write
   // port's register, the bus cycle lines up exactly with the write state.
   always_comb begin
      wr_next = '0;
      case (next_state)
         ST_WR_PL: begin
            // WR_PL is only ever entered from IDLE, on the same edge that
            // latches period, so the low half comes straight from the input.
            wr_next.vld  = 1'b1;
            wr_next.addr = TM_ADDR_PERIOD_L;
            wr_next.dat  = (state == ST_IDLE) ? period[15:0] : period_q[15:0];
         end
         ST_WR_PH: begin
            wr_next.vld  = 1'b1;
            wr_next.addr = TM_ADDR_PERIOD_H;
            wr_next.dat  = period_q[31:16];
         end
         ST_WR_CTRL: begin
            wr_next.vld  = 1'b1;
            wr_next.addr = TM_ADDR_CONTROL;
            wr_next.dat  = CTRL_RUN_WORD;
         end
         ST_CLR: begin
            wr_next.vld  = 1'b1;
            wr_next.addr = TM_ADDR_STATUS;
            wr_next.dat  = STATUS_CLEAR_WORD;
         end
         ST_WR_STOP: begin
            wr_next.vld  = 1'b1;
            wr_next.addr = TM_ADDR_CONTROL;
            wr_next.dat  = CTRL_HALT_WORD;
         end
         ST_WR_FINAL: begin
            wr_next.vld  = 1'b1;
            wr_next.addr = TM_ADDR_STATUS;
            wr_next.dat  = STATUS_CLEAR_WORD;
         end
         default: begin
            wr_next = '0;
         end
      endcase
   end

   assign busy = (state != ST_IDLE);

   // ------------------------------------------------------------------
   // Run parameters, tick counter and status pulses
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         period_q     <= '0;
         burst_q      <= '0;
         tick_count_q <= '0;
         tick_q       <= 1'b0;
         done_q       <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         tick_q <= irq_service;
         // WR_FINAL always hands back to IDLE, so this marks the end of a run.
         done_q <= (state == ST_WR_FINAL);
         err_q  <= reject_start;

         if (accept_start) begin
            period_q     <= period;
            burst_q      <= burst_count;
            tick_count_q <= '0;
         end else if (irq_service) begin
            // Unlimited runs simply wrap the counter.
            tick_count_q <= tick_count_q + 16'd1;
         end
      end
   end

   assign tick       = tick_q;
   assign tick_count = tick_count_q;
   assign done       = done_q;
   assign err        = err_q;

   ads131_tm_write_port u_write_port (
      .clk           (clk),
      .reset_n       (reset_n),
      .wr_req        (wr_next.vld),
      .wr_address    (wr_next.addr),
      .wr_data       (wr_next.dat),
      .tm_address    (tm_address),
      .tm_chipselect (tm_chipselect),
      .tm_write_n    (tm_write_n),
      .tm_writedata  (tm_writedata)
   );

endmodule

// File: tb/tb_ads131_timer_sequencer.sv
// Bench for ads131_timer_sequencer: directed steps, a behavioural interval
// timer, and a queue of expected timer bus writes checked as they appear.
module tb_ads131_timer_sequencer;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        start;
   logic        stop;
   logic [31:0] period;
   logic [15:0] burst_count;
   logic        tm_irq;
   logic [2:0]  tm_address;
   logic        tm_chipselect;
   logic        tm_write_n;
   logic [15:0] tm_writedata;
   logic        tick;
   logic [15:0] tick_count;
   logic        busy;
   logic        done;
   logic        err;

   typedef struct packed {
      logic [2:0]  addr;
      logic [15:0] dat;
   } wr_t;

   wr_t exp_q[$];
   wr_t mon_got;
   wr_t mon_exp;

   int vecs = 0;
   int miscompares = 0;
   int cyc = 0;

   always #5 clk = ~clk;

   ads131_timer_sequencer dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .start         (start),
      .stop          (stop),
      .period        (period),
      .burst_count   (burst_count),
      .tm_irq        (tm_irq),
      .tm_address    (tm_address),
      .tm_chipselect (tm_chipselect),
      .tm_write_n    (tm_write_n),
      .tm_writedata  (tm_writedata),
      .tick          (tick),
      .tick_count    (tick_count),
      .busy          (busy),
      .done          (done),
      .err           (err)
   );

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vecs++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Behavioural interval timer sharing the reset net with the sequencer.
   logic [31:0] m_period;
   logic [31:0] m_cnt;
   logic        m_run;
   logic        m_cont;
   logic        inject;

   always @(posedge clk) begin
      if (!reset_n) begin
         m_period <= '0;
         m_cnt    <= '0;
         m_run    <= 1'b0;
         m_cont   <= 1'b0;
         tm_irq   <= 1'b0;
      end else begin
         if (tm_chipselect && !tm_write_n) begin
            case (tm_address)
               3'd0: tm_irq <= 1'b0;
               3'd1: begin
                  if (tm_writedata[3]) begin
                     m_run <= 1'b0;
                  end else if (tm_writedata[2]) begin
                     m_run  <= 1'b1;
                     m_cont <= tm_writedata[1];
                     m_cnt  <= m_period;
                  end
               end
               3'd2: m_period[15:0]  <= tm_writedata;
               3'd3: m_period[31:16] <= tm_writedata;
               default: ;
            endcase
         end
         if (m_run) begin
            if (m_cnt == 32'd0) begin
               tm_irq <= 1'b1;
               m_cnt  <= m_period;
               if (!m_cont) m_run <= 1'b0;
            end else begin
               m_cnt <= m_cnt - 32'd1;
            end
         end
         if (inject) tm_irq <= 1'b1;
      end
   end

   // Bus monitor: every write cycle must match the next expected write.
   always @(negedge clk) begin
      if (tm_chipselect === 1'b1) begin
         mon_got = {tm_address, tm_writedata};
         chk("bus_write_expected", 32'(exp_q.size() > 0), 32'd1);
         chk("bus_write_n_low", 32'(tm_write_n), 32'd0);
         if (exp_q.size() > 0) begin
            mon_exp = exp_q.pop_front();
            chk("bus_write", 32'(mon_got), 32'(mon_exp));
         end
      end
   end

   task automatic push_wr(input logic [2:0] a, input logic [15:0] d);
      exp_q.push_back({a, d});
   endtask

   task automatic wait_tick(input int budget, output int at);
      at = -1;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (tick === 1'b1) begin
            at = cyc;
            break;
         end
      end
   endtask

   task automatic wait_done(input int budget, output int at);
      at = -1;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (done === 1'b1) begin
            at = cyc;
            break;
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired observed=running required=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      int t1, t2, t3, d, k;

      reset_n = 1'b0;
      start = 1'b0;
      stop = 1'b0;
      period = '0;
      burst_count = '0;
      inject = 1'b0;

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_cs", 32'(tm_chipselect), 32'd0);
      chk("rst_wn", 32'(tm_write_n), 32'd1);
      chk("rst_addr", 32'(tm_address), 32'd0);
      chk("rst_data", 32'(tm_writedata), 32'd0);
      chk("rst_tick", 32'(tick), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_tcnt", 32'(tick_count), 32'd0);
      @(posedge clk); #1 reset_n = 1'b1;

      // Burst of 3, period 99
      @(posedge clk); #1;
      period = 32'd99; burst_count = 16'd3; start = 1'b1;
      push_wr(3'd2, 16'h0063);
      push_wr(3'd3, 16'h0000);
      push_wr(3'd1, 16'h0007);
      push_wr(3'd0, 16'h0000);
      push_wr(3'd0, 16'h0000);
      push_wr(3'd0, 16'h0000);
      push_wr(3'd1, 16'h0008);
      push_wr(3'd0, 16'h0000);
      @(posedge clk); #1 start = 1'b0;
      @(negedge clk);
      chk("lat_first_write_cs", 32'(tm_chipselect), 32'd1);
      chk("lat_first_write_addr", 32'(tm_address), 32'd2);
      chk("busy_after_start", 32'(busy), 32'd1);
      wait_tick(300, t1);
      chk("burst_tick1_seen", 32'(t1 >= 0), 32'd1);
      chk("burst_tcnt1", 32'(tick_count), 32'd1);
      wait_tick(300, t2);
      wait_tick(300, t3);
      chk("burst_tick_gap12", 32'(t2 - t1), 32'd100);
      chk("burst_tick_gap23", 32'(t3 - t2), 32'd100);
      chk("burst_tcnt3", 32'(tick_count), 32'd3);
      wait_done(50, d);
      chk("burst_done_seen", 32'(d >= 0), 32'd1);
      chk("burst_idle_at_done", 32'(busy), 32'd0);
      @(negedge clk);
      chk("burst_done_one_cycle", 32'(done), 32'd0);
      chk("burst_tcnt_hold", 32'(tick_count), 32'd3);

      // Rejected start, period just below the minimum
      @(posedge clk); #1;
      period = 32'd15; burst_count = 16'd0; start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      @(negedge clk);
      chk("rej_err_pulse", 32'(err), 32'd1);
      chk("rej_busy", 32'(busy), 32'd0);
      chk("rej_no_bus", 32'(tm_chipselect), 32'd0);
      @(negedge clk);
      chk("rej_err_one_cycle", 32'(err), 32'd0);
      chk("rej_tcnt_hold", 32'(tick_count), 32'd3);

      // start+stop together in IDLE is ignored without err
      @(posedge clk); #1;
      period = 32'd99; start = 1'b1; stop = 1'b1;
      @(posedge clk); #1 start = 1'b0; stop = 1'b0;
      @(negedge clk);
      chk("startstop_busy", 32'(busy), 32'd0);
      chk("startstop_err", 32'(err), 32'd0);

      // Minimum period accepted; start during RUN ignored; stop with tm_irq
      @(posedge clk); #1;
      period = 32'd16; burst_count = 16'd0; start = 1'b1;
      push_wr(3'd2, 16'h0010);
      push_wr(3'd3, 16'h0000);
      push_wr(3'd1, 16'h0007);
      push_wr(3'd0, 16'h0000);
      @(posedge clk); #1 start = 1'b0;
      wait_tick(100, t1);
      chk("min_tick_seen", 32'(t1 >= 0), 32'd1);
      chk("min_tcnt1", 32'(tick_count), 32'd1);
      @(posedge clk); #1;
      period = 32'd15; start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      @(negedge clk);
      chk("busy_start_no_err", 32'(err), 32'd0);
      chk("busy_start_still_busy", 32'(busy), 32'd1);
      k = 0;
      while (k < 100 && tm_irq !== 1'b1) begin
         @(negedge clk);
         k++;
      end
      chk("irq_seen_for_stop", 32'(tm_irq), 32'd1);
      stop = 1'b1;
      push_wr(3'd1, 16'h0008);
      push_wr(3'd0, 16'h0000);
      @(posedge clk); #1 stop = 1'b0;
      @(negedge clk);
      chk("stopirq_no_tick", 32'(tick), 32'd0);
      chk("stopirq_tcnt", 32'(tick_count), 32'd1);
      chk("stopirq_wr_stop_addr", 32'(tm_address), 32'd1);
      chk("stopirq_wr_stop_data", 32'(tm_writedata), 32'd8);
      wait_done(20, d);
      chk("stopirq_done_seen", 32'(d >= 0), 32'd1);

      // Large period, unlimited burst, stop ends the run
      @(posedge clk); #1;
      period = 32'h0001_0000; burst_count = 16'd0; start = 1'b1;
      push_wr(3'd2, 16'h0000);
      push_wr(3'd3, 16'h0001);
      push_wr(3'd1, 16'h0007);
      @(posedge clk); #1 start = 1'b0;
      for (int n = 1; n <= 2; n++) begin
         repeat (8) @(posedge clk);
         #1 inject = 1'b1;
         push_wr(3'd0, 16'h0000);
         @(posedge clk); #1 inject = 1'b0;
         wait_tick(20, t1);
         chk("unl_tick_seen", 32'(t1 >= 0), 32'd1);
         chk("unl_tcnt", 32'(tick_count), 32'(n));
      end
      repeat (4) @(posedge clk);
      #1 stop = 1'b1;
      push_wr(3'd1, 16'h0008);
      push_wr(3'd0, 16'h0000);
      @(posedge clk); #1 stop = 1'b0;
      @(negedge clk);
      chk("unl_stop_next_cs", 32'(tm_chipselect), 32'd1);
      chk("unl_stop_next_addr", 32'(tm_address), 32'd1);
      wait_done(20, d);
      chk("unl_done_seen", 32'(d >= 0), 32'd1);
      chk("unl_tcnt_final", 32'(tick_count), 32'd2);

      // Reset during WR_PH
      @(posedge clk); #1;
      period = 32'd99; burst_count = 16'd0; start = 1'b1;
      push_wr(3'd2, 16'h0063);
      push_wr(3'd3, 16'h0000);
      @(posedge clk); #1 start = 1'b0;
      @(posedge clk); #1 reset_n = 1'b0;
      @(negedge clk);
      chk("mid_rst_in_wr_ph", 32'(tm_address), 32'd3);
      @(posedge clk); #1;
      @(negedge clk);
      chk("mid_rst_cs", 32'(tm_chipselect), 32'd0);
      chk("mid_rst_wn", 32'(tm_write_n), 32'd1);
      chk("mid_rst_addr", 32'(tm_address), 32'd0);
      chk("mid_rst_data", 32'(tm_writedata), 32'd0);
      chk("mid_rst_busy", 32'(busy), 32'd0);
      chk("mid_rst_tcnt", 32'(tick_count), 32'd0);
      chk("mid_rst_tick", 32'(tick), 32'd0);
      chk("mid_rst_done", 32'(done), 32'd0);
      chk("mid_rst_err", 32'(err), 32'd0);
      @(posedge clk); #1 reset_n = 1'b1;
      repeat (5) @(posedge clk);
      @(negedge clk);
      chk("no_write_after_reset", 32'(busy), 32'd0);
      chk("expected_writes_drained", 32'(exp_q.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
      $finish;
   end

endmodule

// File: doc/ads131_timer_sequencer.md
ADS131_TIMER_SEQUENCER -- requirements
Module: ads131_timer_sequencer

Interface
REQ-001 MIN_PERIOD, 16, smallest accepted 32-bit load value; smaller values are rejected.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 reset_n  in  1  synchronous, active-low reset.
REQ-004 start  in  1  one-cycle request to program and run the timer.
REQ-005 stop  in  1  one-cycle request to halt the timer.
REQ-006 period  in  32  timer load value (timeout every period+1 clocks), sampled on accepted start.
REQ-007 burst_count  in  16  timeouts per run (0 = unlimited), sampled on accepted start.
REQ-008 tm_irq  in  1  interval-timer interrupt (level, held until status write).
REQ-009 tm_address  out  3  timer register address.
REQ-010 tm_chipselect  out  1  timer select, asserted only on write cycles.
REQ-011 tm_write_n  out  1  timer write strobe, active-low.
REQ-012 tm_writedata  out  16  timer write data.
REQ-013 tick  out  1  one-cycle pulse per serviced timeout (ADC sample trigger).
REQ-014 tick_count  out  16  timeouts serviced in current/last run.
REQ-015 busy  out  1  high in every state except IDLE.
REQ-016 done  out  1  one-cycle pulse on return to IDLE after a run.
REQ-017 err  out  1  one-cycle pulse when a start is rejected.

Function
REQ-018 Timer map: addr 0 status (any write clears timeout), 1 control (b0 ITO, b1 CONT, b2 START, b3 STOP), 2 period_l, 3 period_h; each write completes in one cycle, no waitrequest.
REQ-019 States: IDLE, WR_PL, WR_PH, WR_CTRL, RUN, CLR, CLR_HOLD, WR_STOP, WR_FINAL.
REQ-020 Bus outputs registered: each write state drives chipselect=1, write_n=0, address, writedata for exactly that cycle; otherwise chipselect=0, write_n=1, address=0, writedata=0.
REQ-021 IDLE: start with stop=0 and period>=MIN_PERIOD latches period/burst_count, clears tick_count, goes WR_PL; period<MIN_PERIOD pulses err next cycle, stays IDLE.
REQ-022 WR_PL writes period[15:0] to addr 2; WR_PH writes period[31:16] to addr 3; WR_CTRL writes 0x0007 to addr 1; back-to-back, no gap cycles.
REQ-023 RUN: tm_irq=1 and stop=0 -> tick pulses next cycle, tick_count increments (wraps 0xFFFF->0), goes CLR.
REQ-024 CLR writes 0x0000 to addr 0; CLR_HOLD ignores tm_irq one cycle, then returns to RUN, or goes WR_STOP if burst_count!=0 and tick_count==burst_count.
REQ-025 stop in any state other than IDLE/WR_STOP/WR_FINAL goes to WR_STOP next cycle; coincident tm_irq in RUN produces no tick.
REQ-026 WR_STOP writes 0x0008 to addr 1 (halt, interrupt disabled); WR_FINAL writes 0x0000 to addr 0; then IDLE with done pulse.
REQ-027 start while busy ignored; start+stop together in IDLE ignored.
REQ-028 tick_count holds last value in IDLE until next accepted start.
REQ-029 Start-to-first-timer-write latency: 1 cycle (WR_PL entered on edge after start).

Reset
REQ-030 reset_n=0 at a rising edge: state IDLE, chipselect=0, write_n=1, address=0, writedata=0, tick=0, done=0, err=0, busy=0, tick_count=0, latched period/burst_count=0.
REQ-031 Reset mid-run issues no stop write; timer is reset on the same net.

Structure
REQ-032 Shared package ads131_timer_pkg holds timer register addresses, control bit positions, control words 0x0007/0x0008 and the state enum.
REQ-033 Single sub-module ads131_tm_write_port registers the four bus outputs from a one-cycle write request.

Verification
REQ-034 period=99, burst_count=3, start -> writes (2,0x0063),(3,0x0000),(1,0x0007) on 3 consecutive cycles; 3 ticks ~100 clocks apart; (1,0x0008),(0,0x0000); done; tick_count=3.
REQ-035 period=0x0001_0000, burst_count=0 -> writes (2,0x0000),(3,0x0001); ticks continue until stop; stop -> WR_STOP next cycle.
REQ-036 period=15 -> err one-cycle pulse, no bus activity, busy stays 0.
REQ-037 stop asserted same cycle as tm_irq in RUN -> no tick, tick_count unchanged, WR_STOP then WR_FINAL.
REQ-038 start during RUN -> ignored; reset_n low during WR_PH -> all outputs at reset values next cycle.
